ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//   EX/MEM boundary register, directly downstream of the ALU. Resolves branches/jumps
//   from the ALU compare flag, issues a registered one-cycle PC redirect/flush,
//   squashes the wrong-path instruction behind it, and registers the result bundle for MEM.
//   Also keeps branch statistics counters.
// PARAMETERS
//   XLEN   32  datapath width
//   CNT_W  32  width of branch statistics counters (saturating)
// PORTS
//   clk              in   1     single clock, rising edge
//   rst_n            in   1     asynchronous active-low reset
//   ex_valid         in   1     EX holds a real instruction
//   ex_pc            in   XLEN  PC of EX instruction
//   ex_imm           in   XLEN  sign-extended immediate
//   ex_alu_result    in   XLEN  ALU rd_data (JALR: rs1+imm)
//   ex_branch_alu    in   1     ALU compare flag (also 1 on ADD, so always gated)
//   ex_is_branch     in   1     conditional branch
//   ex_is_jal        in   1     JAL
//   ex_is_jalr       in   1     JALR
//   ex_rs2_data      in   XLEN  store data
//   ex_rd_addr       in   5     destination register
//   ex_reg_write     in   1     writes rd
//   ex_mem_read      in   1     load
//   ex_mem_write     in   1     store
//   ex_funct3        in   3     access size/sign
//   mem_stall        in   1     MEM cannot accept; hold all pipeline registers
//   redirect_valid   out  1     one-cycle pulse: fetch from redirect_pc, flush IF/ID/EX
//   redirect_pc      out  XLEN  redirect target
//   mem_valid        out  1     MEM stage holds a real instruction
//   mem_result       out  XLEN  ALU result, or PC+4 for JAL/JALR
//   mem_store_data   out  XLEN  registered ex_rs2_data
//   mem_rd_addr      out  5     registered rd
//   mem_reg_write    out  1     registered, forced 0 when !mem_valid
//   mem_mem_read     out  1     registered, forced 0 when !mem_valid
//   mem_mem_write    out  1     registered, forced 0 when !mem_valid
//   mem_funct3       out  3     registered funct3
//   mem_exc_misalign out  1     taken target not 4-byte aligned
//   br_count         out  CNT_W retired conditional branches
//   br_taken_count   out  CNT_W taken conditional branches
// BEHAVIOUR
//   - Reset (async, rst_n=0): every output and internal register = 0; effective on assertion.
//   - accept = ex_valid & !redirect_valid & !mem_stall. redirect_valid high => EX is wrong-path, dropped.
//   - taken = (ex_is_branch & ex_branch_alu) | ex_is_jal | ex_is_jalr.
//   - target: branch/JAL = ex_pc+ex_imm; JALR = ex_alu_result & ~1. All sums mod 2^XLEN.
//   - misalign = taken & (target[1:0]!=0).
//   - On accept: latch bundle; mem_valid<=1; mem_result<=(jal|jalr)?ex_pc+4:ex_alu_result;
//     mem_exc_misalign<=misalign; misaligned instruction still writes rd (trap handled in WB).
//   - On accept & taken & !misalign: redirect_valid<=1, redirect_pc<=target at the next edge.
//     Otherwise redirect_valid<=0; it is never high two consecutive cycles.
//   - !accept & !mem_stall: mem_valid<=0 (bubble); other data fields don't-care.
//   - mem_stall=1: all mem_* held; counters held; redirect_valid still clears after one cycle.
//     Fetch gives redirect priority over stall.
//   - Counters: on accept & ex_is_branch, br_count+=1, br_taken_count+=taken;
//     both saturate at 2^CNT_W-1, no wrap.
//   - Latency: EX result visible on mem_* one cycle after accept. Redirect one cycle after
//     accept; penalty = 3 squashed slots.
// STRUCTURE
//   - defines.v (shared): WB/access-size funct3 encodings, XLEN default.
//   - Sub-module branch_resolve (combinational): taken, target, misalign, link = pc+4.
//   - This file: accept logic, pipeline registers, redirect pulse, counters.
// TESTING
//   1 Reset mid-run: rst_n low asynchronously -> all outputs 0 before next clk edge.
//   2 BEQ pc=0x100 imm=0x20 flag=1 -> next cycle redirect_valid=1, redirect_pc=0x120;
//     following EX instr dropped (mem_valid=0); br_taken_count=1.
//   3 ADD with flag=1, is_branch=0 -> no redirect; mem_result=ALU sum; br_count unchanged.
//   4 JALR alu_result=0x2003 pc=0x40 -> redirect_pc=0x2002, mem_exc_misalign=1,
//     no redirect; mem_result=0x44.
//   5 mem_stall 3 cycles with valid load in MEM -> mem_* bit-identical; EX not consumed.
//   6 CNT_W=4: 16 not-taken branches -> br_count=15 (saturated), br_taken_count=0.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and helpers for the EX/MEM boundary stage.
// Holds the datapath defaults, access-size encodings and the alignment test.
package ex_mem_stage_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned LINK_OFFSET = 4;

  typedef enum logic [2:0] {
    F3_BYTE  = 3'b000,
    F3_HALF  = 3'b001,
    F3_WORD  = 3'b010,
    F3_BYTEU = 3'b100,
    F3_HALFU = 3'b101
  } access_size_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational branch/jump resolution: taken decision, target, link address
// and target-alignment fault.
module ex_mem_stage_branch_resolve
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            branch_alu_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] link_o,
  output logic            misalign_o
);

  always_comb begin
    // The ALU flag is also raised by plain ADDs, so it only counts for branches.
    taken_o    = (is_branch_i & branch_alu_i) | is_jal_i | is_jalr_i;
    target_o   = is_jalr_i ? (alu_result_i & ~XLEN'(1)) : (pc_i + imm_i);
    link_o     = pc_i + XLEN'(LINK_OFFSET);
    misalign_o = taken_o & is_misaligned(target_o[1:0]);
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: accepts EX, resolves control flow, issues a one-cycle
// redirect pulse, squashes the wrong-path slot and keeps saturating branch statistics.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic             ex_branch_alu,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [XLEN-1:0]  ex_rs2_data,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [2:0]       ex_funct3,
  input  logic             mem_stall,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             mem_valid,
  output logic [XLEN-1:0]  mem_result,
  output logic [XLEN-1:0]  mem_store_data,
  output logic [4:0]       mem_rd_addr,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [2:0]       mem_funct3,
  output logic             mem_exc_misalign,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] br_taken_count
);

  logic            taken;
  logic            misalign;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            accept;

  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q,    redirect_pc_d;
  logic             mem_valid_q,      mem_valid_d;
  logic [XLEN-1:0]  mem_result_q,     mem_result_d;
  logic [XLEN-1:0]  mem_store_data_q, mem_store_data_d;
  logic [4:0]       mem_rd_addr_q,    mem_rd_addr_d;
  logic             mem_reg_write_q,  mem_reg_write_d;
  logic             mem_mem_read_q,   mem_mem_read_d;
  logic             mem_mem_write_q,  mem_mem_write_d;
  logic [2:0]       mem_funct3_q,     mem_funct3_d;
  logic             mem_misalign_q,   mem_misalign_d;
  logic [CNT_W-1:0] br_count_q,       br_count_d;
  logic [CNT_W-1:0] br_taken_q,       br_taken_d;

  ex_mem_stage_branch_resolve #(.XLEN(XLEN)) u_resolve (
    .pc_i         (ex_pc),
    .imm_i        (ex_imm),
    .alu_result_i (ex_alu_result),
    .branch_alu_i (ex_branch_alu),
    .is_branch_i  (ex_is_branch),
    .is_jal_i     (ex_is_jal),
    .is_jalr_i    (ex_is_jalr),
    .taken_o      (taken),
    .target_o     (target),
    .link_o       (link),
    .misalign_o   (misalign)
  );

  // While a redirect is out, the instruction sitting in EX is wrong-path.
  assign accept = ex_valid & ~redirect_valid_q & ~mem_stall;

  always_comb begin
    // NOTE: every next-state signal gets a hold/default value first so no path
    // through the branches below leaves it unassigned (which would infer a latch).
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mem_valid_d      = mem_valid_q;
    mem_result_d     = mem_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_addr_d    = mem_rd_addr_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_read_d   = mem_mem_read_q;
    mem_mem_write_d  = mem_mem_write_q;
    mem_funct3_d     = mem_funct3_q;
    mem_misalign_d   = mem_misalign_q;
    br_count_d       = br_count_q;
    br_taken_d       = br_taken_q;

    if (accept) begin
      mem_valid_d      = 1'b1;
      mem_result_d     = (ex_is_jal | ex_is_jalr) ? link : ex_alu_result;
      mem_store_data_d = ex_rs2_data;
      mem_rd_addr_d    = ex_rd_addr;
      mem_reg_write_d  = ex_reg_write;
      mem_mem_read_d   = ex_mem_read;
      mem_mem_write_d  = ex_mem_write;
      mem_funct3_d     = ex_funct3;
      mem_misalign_d   = misalign;
      if (taken) begin
        // A misaligned target is still recorded but traps in WB instead of redirecting.
        redirect_pc_d    = target;
        redirect_valid_d = ~misalign;
      end
      if (ex_is_branch) begin
        if (br_count_q != '1) br_count_d = br_count_q + CNT_W'(1);
        if (taken && (br_taken_q != '1)) br_taken_d = br_taken_q + CNT_W'(1);
      end
    end else if (!mem_stall) begin
      mem_valid_d    = 1'b0;
      mem_misalign_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mem_valid_q      <= 1'b0;
      mem_result_q     <= '0;
      mem_store_data_q <= '0;
      mem_rd_addr_q    <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_funct3_q     <= '0;
      mem_misalign_q   <= 1'b0;
      br_count_q       <= '0;
      br_taken_q       <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mem_valid_q      <= mem_valid_d;
      mem_result_q     <= mem_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_addr_q    <= mem_rd_addr_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_funct3_q     <= mem_funct3_d;
      mem_misalign_q   <= mem_misalign_d;
      br_count_q       <= br_count_d;
      br_taken_q       <= br_taken_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign mem_valid        = mem_valid_q;
  assign mem_result       = mem_result_q;
  assign mem_store_data   = mem_store_data_q;
  assign mem_rd_addr      = mem_rd_addr_q;
  assign mem_reg_write    = mem_valid_q & mem_reg_write_q;
  assign mem_mem_read     = mem_valid_q & mem_mem_read_q;
  assign mem_mem_write    = mem_valid_q & mem_mem_write_q;
  assign mem_funct3       = mem_funct3_q;
  assign mem_exc_misalign = mem_misalign_q;
  assign br_count         = br_count_q;
  assign br_taken_count   = br_taken_q;

endmodule
